cy_status_reg_v2_00: RTL

//  Parametrised status register: 1..32 hardware status nets sampled into a register file the CPU reads a byte at a time.
//  Per-bit sticky (latch-high, clear-on-read) or transparent mode.

---
 rtl/cy_status_reg_v2_00.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cy_status_reg_v2_00.sv
// cy_status_reg_v2_00 - parametrised status register.
//
// Samples 1..32 hardware status nets into a register that the CPU reads a byte
// at a time. Each bit is either transparent (follows its input every clock) or
// sticky (latches high, clears when its byte is read). A runtime-writable
// interrupt mask gates the register into a single registered level interrupt.
//
// Optional feature macro: CY_STATUS_REG_V2_SYNC_EN
//   defined   - each status bit passes a 2-flop synchroniser (adds 2 clocks)
//   undefined - status must already be synchronous to clock
//
// Ports:
//   clock      in   1           rising-edge clock
//   reset_n    in   1           synchronous reset, active-low
//   status     in   NUM_INPUTS  raw status nets
//   rd_en      in   1           CPU read strobe
//   rd_addr    in   2           read byte select
//   rd_data    out  8           registered read data, held while rd_en=0
//   rd_valid   out  1           single-cycle pulse one clock after rd_en
//   mask_wr    in   1           interrupt-mask byte write strobe
//   mask_addr  in   2           mask write byte select
//   mask_data  in   8           mask byte value
//   intr       out  1           registered level interrupt

module cy_status_reg_v2_00 #(
  parameter int unsigned NUM_INPUTS    = 8,
  parameter logic [31:0] STICKY_MASK   = 32'h0,
  parameter logic [31:0] INT_MASK_INIT = 32'h7F
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] status,
  input  logic                  rd_en,
  input  logic [1:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  mask_wr,
  input  logic [1:0]            mask_addr,
  input  logic [7:0]            mask_data,
  output logic                  intr
);

  localparam int unsigned NUM_BYTES = (NUM_INPUTS + 7) / 8;

  // Bits at or above NUM_INPUTS are held at zero everywhere, so byte slices of
  // the 32-bit internal vectors read 0 in the unused upper bits automatically.
  localparam logic [31:0] VALID_BITS  = (NUM_INPUTS >= 32) ? 32'hFFFF_FFFF
                                                           : ((32'd1 << NUM_INPUTS) - 32'd1);
  localparam logic [31:0] STICKY_BITS = STICKY_MASK & VALID_BITS;
  localparam logic [31:0] MASK_RESET  = INT_MASK_INIT & VALID_BITS;

  logic [NUM_INPUTS-1:0] status_in;
  logic [31:0]           status_ext;
  logic [31:0]           sts_q, sts_d;
  logic [31:0]           mask_q, mask_d;
  logic [31:0]           rd_clr;
  logic [7:0]            rd_byte;
  logic                  rd_mapped;
  logic                  mask_mapped;
  logic                  intr_d;

`ifdef CY_STATUS_REG_V2_SYNC_EN
  logic [NUM_INPUTS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= status;
      sync2_q <= sync1_q;
    end
  end

  assign status_in = sync2_q;
`else
  assign status_in = status;
`endif

  always_comb begin
    status_ext                 = '0;
    status_ext[NUM_INPUTS-1:0] = status_in;
  end

  assign rd_mapped   = (32'(rd_addr) < NUM_BYTES);
  assign mask_mapped = (32'(mask_addr) < NUM_BYTES);

  // Read data comes from the register as held before the edge; unmapped
  // addresses return zero and clear nothing.
  always_comb begin
    rd_byte = 8'h00;
    rd_clr  = '0;
    if (rd_mapped) begin
      rd_byte = sts_q[{rd_addr, 3'b000} +: 8];
      if (rd_en) begin
        rd_clr[{rd_addr, 3'b000} +: 8] = 8'hFF;
      end
    end
  end

  // Sticky bits: clear-on-read is applied before OR-ing in the new input, so
  // an input high in the read cycle keeps the bit set (set wins).
  always_comb begin
    sts_d = ((status_ext & ~STICKY_BITS)
            | (STICKY_BITS & ((sts_q & ~rd_clr) | status_ext))) & VALID_BITS;
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_wr && mask_mapped) begin
      mask_d[{mask_addr, 3'b000} +: 8] = mask_data;
    end
    mask_d = mask_d & VALID_BITS;
  end

  // Interrupt uses next-state values so it lines up with the sts_q capture.
  assign intr_d = |(sts_d & mask_d);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sts_q    <= '0;
      mask_q   <= MASK_RESET;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      intr     <= 1'b0;
    end else begin
      sts_q    <= sts_d;
      mask_q   <= mask_d;
      rd_valid <= rd_en;
      intr     <= intr_d;
      if (rd_en) begin
        rd_data <= rd_byte;
      end
    end
  end

endmodule
